// File: rtl/timer_mode_ctrl.sv
// Purpose : mode sequencer for a countdown timer driven by two buttons and a 1 Hz tick.
// Latency : every output is a flop; it reflects an input event from the clk edge that samples it.
// Backpr. : none; strobes are consumed in the cycle they arrive, and a bt2 strobe that coincides with a bt1 event is dropped.
//
// Ports:
//   clk, reset            - system clock; asynchronous active-high reset
//   bt1_rise, bt1_fall    - button1 press/release strobes (synchronised, 1 cycle)
//   bt2_rise              - button2 press strobe (synchronised, 1 cycle)
//   tick                  - 1 Hz strobe, 1 cycle
//   count_zero            - level, countdown value is 00:00
//   mode                  - 0 IDLE, 1 RUN, 2 PAUSE, 3 PROG, 4 ALARM
//   cnt_run/flicker_on/alarm - state levels for RUN/PROG/ALARM
//   cnt_load/cnt_reset/prog_inc - single-cycle command pulses to the counter
//   prog_sel              - digit under edit while in PROG
module timer_mode_ctrl #(
  parameter int unsigned LONG_PRESS = 5,
  parameter int unsigned ALARM_LEN  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bt1_rise,
  input  logic       bt1_fall,
  input  logic       bt2_rise,
  input  logic       tick,
  input  logic       count_zero,
  output logic [2:0] mode,
  output logic       cnt_run,
  output logic       flicker_on,
  output logic       alarm,
  output logic       cnt_load,
  output logic       cnt_reset,
  output logic       prog_inc,
  output logic [1:0] prog_sel
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_PROG  = 3'd3,
    S_ALARM = 3'd4
  } state_t;

  localparam logic [7:0] LP_SAT = 8'(LONG_PRESS);
  localparam logic [7:0] LP_M1  = 8'(LONG_PRESS - 1);
  localparam logic [7:0] AL_M1  = 8'(ALARM_LEN - 1);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;
  logic       held_q, held_d;
  // Set once the current press has been consumed (long press or alarm
  // acknowledge) so nothing further is classified from it.
  logic       ign_q, ign_d;
  logic       run_d, flk_d, alm_d;
  logic       load_d, creset_d, inc_d;
  logic       run_q, flk_q, alm_q;
  logic       load_q, creset_q, inc_q;

  logic       short_ev, long_ev, bt2_ev, bt1_any;

  always_comb begin
    bt1_any  = bt1_rise | bt1_fall;
    short_ev = bt1_fall & held_q & ~ign_q;
    // Long press fires on the tick that takes the hold count to LONG_PRESS;
    // a release or re-press in the same cycle means the button is not held.
    long_ev  = tick & held_q & ~ign_q & ~bt1_any & (hold_cnt_q == LP_M1);
    // button1 activity wins over a coincident button2 strobe
    bt2_ev   = bt2_rise & ~bt1_any & ~long_ev;

    state_d     = state_q;
    sel_d       = sel_q;
    held_d      = held_q;
    ign_d       = ign_q;
    hold_cnt_d  = hold_cnt_q;
    alarm_cnt_d = 8'd0;
    load_d      = 1'b0;
    creset_d    = 1'b0;
    inc_d       = 1'b0;

    // Press tracking. A tick coinciding with the rise is not counted.
    if (bt1_rise) begin
      held_d     = 1'b1;
      ign_d      = 1'b0;
      hold_cnt_d = 8'd0;
    end else begin
      if (bt1_fall) held_d = 1'b0;
      if (tick && held_q && (hold_cnt_q < LP_SAT)) hold_cnt_d = hold_cnt_q + 8'd1;
    end
    if (long_ev) ign_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (short_ev) begin
          if (!count_zero) state_d = S_RUN;
        end else if (long_ev) begin
          state_d = S_PROG;
        end else if (bt2_ev) begin
          creset_d = 1'b1;
        end
      end
      S_RUN: begin
        // reaching zero outranks a simultaneous short press
        if (count_zero)    state_d = S_ALARM;
        else if (short_ev) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (short_ev) begin
          state_d = count_zero ? S_IDLE : S_RUN;
        end else if (long_ev) begin
          state_d = S_PROG;
        end else if (bt2_ev) begin
          creset_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_PROG: begin
        if (short_ev) begin
          if (sel_q == 2'd3) begin
            load_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end else if (long_ev) begin
          state_d = S_IDLE;
        end else if (bt2_ev) begin
          inc_d = 1'b1;
        end
      end
      S_ALARM: begin
        if (bt1_rise || bt2_ev) begin
          state_d = S_IDLE;
          // the release of an acknowledging button1 press must not act later
          if (bt1_rise) ign_d = 1'b1;
        end else if (tick) begin
          if (alarm_cnt_q == AL_M1) state_d = S_IDLE;
          else alarm_cnt_d = alarm_cnt_q + 8'd1;
        end else begin
          alarm_cnt_d = alarm_cnt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // digit index only has meaning in PROG; every entry starts at digit 0
    if (state_d != S_PROG) sel_d = 2'd0;

    run_d = (state_d == S_RUN);
    flk_d = (state_d == S_PROG);
    alm_d = (state_d == S_ALARM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_q       <= 2'd0;
      hold_cnt_q  <= 8'd0;
      alarm_cnt_q <= 8'd0;
      held_q      <= 1'b0;
      ign_q       <= 1'b0;
      run_q       <= 1'b0;
      flk_q       <= 1'b0;
      alm_q       <= 1'b0;
      load_q      <= 1'b0;
      creset_q    <= 1'b0;
      inc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      hold_cnt_q  <= hold_cnt_d;
      alarm_cnt_q <= alarm_cnt_d;
      held_q      <= held_d;
      ign_q       <= ign_d;
      run_q       <= run_d;
      flk_q       <= flk_d;
      alm_q       <= alm_d;
      load_q      <= load_d;
      creset_q    <= creset_d;
      inc_q       <= inc_d;
    end
  end

  assign mode       = state_q;
  assign prog_sel   = sel_q;
  assign cnt_run    = run_q;
  assign flicker_on = flk_q;
  assign alarm      = alm_q;
  assign cnt_load   = load_q;
  assign cnt_reset  = creset_q;
  assign prog_inc   = inc_q;

endmodule

// File: tb/tb_timer_mode_ctrl.sv
// Bench for timer_mode_ctrl: directed vector table, corner-case sequences,
// then random button/tick traffic compared against a behavioural model.
module tb_timer_mode_ctrl;

  localparam int LP = 5;
  localparam int AL = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bt1_rise = 1'b0, bt1_fall = 1'b0, bt2_rise = 1'b0, tick = 1'b0, count_zero = 1'b0;
  logic [2:0] mode;
  logic       cnt_run, flicker_on, alarm, cnt_load, cnt_reset, prog_inc;
  logic [1:0] prog_sel;

  always #5 clk = ~clk;

  timer_mode_ctrl #(.LONG_PRESS(LP), .ALARM_LEN(AL)) dut (
    .clk(clk), .reset(reset),
    .bt1_rise(bt1_rise), .bt1_fall(bt1_fall), .bt2_rise(bt2_rise),
    .tick(tick), .count_zero(count_zero),
    .mode(mode), .cnt_run(cnt_run), .flicker_on(flicker_on), .alarm(alarm),
    .cnt_load(cnt_load), .cnt_reset(cnt_reset), .prog_inc(prog_inc),
    .prog_sel(prog_sel)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  int m_mode, m_sel, m_ticks, m_alarm;
  bit m_down, m_dead, m_load, m_rst, m_inc;

  function automatic void model_reset();
    m_mode = 0; m_sel = 0; m_ticks = 0; m_alarm = 0;
    m_down = 0; m_dead = 0; m_load = 0; m_rst = 0; m_inc = 0;
  endfunction

  function automatic void model_step(input bit r, input bit f, input bit b2, input bit t, input bit cz);
    bit short_p, long_p, b2_p;
    short_p = f && m_down && !m_dead;
    long_p  = t && m_down && !m_dead && !r && !f && (m_ticks + 1 == LP);
    b2_p    = b2 && !r && !f && !long_p;
    m_load = 0; m_rst = 0; m_inc = 0;
    if (r) begin
      m_down = 1; m_dead = 0; m_ticks = 0;
    end else begin
      if (t && m_down) m_ticks++;
      if (f) m_down = 0;
    end
    if (long_p) m_dead = 1;
    case (m_mode)
      0: if (short_p) begin if (!cz) m_mode = 1; end
         else if (long_p) m_mode = 3;
         else if (b2_p) m_rst = 1;
      1: if (cz) begin m_mode = 4; m_alarm = 0; end
         else if (short_p) m_mode = 2;
      2: if (short_p) m_mode = cz ? 0 : 1;
         else if (long_p) m_mode = 3;
         else if (b2_p) begin m_rst = 1; m_mode = 0; end
      3: if (short_p) begin
           if (m_sel == 3) begin m_load = 1; m_mode = 0; end
           else m_sel++;
         end
         else if (long_p) m_mode = 0;
         else if (b2_p) m_inc = 1;
      4: if (r || b2_p) begin m_mode = 0; if (r) m_dead = 1; end
         else if (t) begin m_alarm++; if (m_alarm == AL) m_mode = 0; end
      default: ;
    endcase
    if (m_mode != 3) m_sel = 0;
  endfunction

  // Expected output word: {mode, cnt_run, flicker_on, alarm, cnt_load, cnt_reset, prog_inc, prog_sel}
  function automatic logic [10:0] ev(input int m, input bit ld, input bit rs, input bit inc, input int sel);
    logic [2:0] mm;
    logic [1:0] ss;
    mm = 3'(m);
    ss = 2'(sel);
    return {mm, (m == 1), (m == 3), (m == 4), ld, rs, inc, ss};
  endfunction

  function automatic logic [10:0] model_vec();
    return ev(m_mode, m_load, m_rst, m_inc, m_sel);
  endfunction

  function automatic logic [10:0] dut_vec();
    return {mode, cnt_run, flicker_on, alarm, cnt_load, cnt_reset, prog_inc, prog_sel};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (mode,run,flk,alm,ld,rst,inc,sel)", name, act, exp);
    end
  endtask

  // One clock: drive strobes, let the edge sample them, compare against the model.
  task automatic step(input bit r, input bit f, input bit b2, input bit t, input bit cz, input string name);
    bt1_rise = r; bt1_fall = f; bt2_rise = b2; tick = t; count_zero = cz;
    @(posedge clk);
    model_step(r, f, b2, t, cz);
    #1;
    check({name, "_model"}, dut_vec(), model_vec());
    bt1_rise = 0; bt1_fall = 0; bt2_rise = 0; tick = 0;
  endtask

  task automatic stepx(input bit r, input bit f, input bit b2, input bit t, input bit cz,
                       input string name, input logic [10:0] exp);
    step(r, f, b2, t, cz, name);
    check(name, dut_vec(), exp);
  endtask

  task automatic pulse_reset(input string name);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check({name, "_async"}, dut_vec(), 11'd0);
    @(posedge clk);
    #1;
    check({name, "_held"}, dut_vec(), 11'd0);
    @(negedge clk) reset = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit r, f, b2, t, cz;
    logic [10:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input bit r, input bit f, input bit b2, input bit t, input bit cz,
                              input logic [10:0] e);
    vec_t v;
    v.r = r; v.f = f; v.b2 = b2; v.t = t; v.cz = cz; v.exp = e;
    vecs.push_back(v);
  endfunction

  initial begin
    // table:      r f b2 t cz   expected
    add(0,0,1,0,0, ev(0,0,1,0,0));   // bt2 in IDLE -> cnt_reset only
    add(0,0,0,0,0, ev(0,0,0,0,0));
    add(1,0,0,0,0, ev(0,0,0,0,0));   // short press with 2 ticks -> RUN on fall
    add(0,0,0,1,0, ev(0,0,0,0,0));
    add(0,0,0,1,0, ev(0,0,0,0,0));
    add(0,1,0,0,0, ev(1,0,0,0,0));
    add(0,0,0,0,0, ev(1,0,0,0,0));
    add(1,0,0,0,0, ev(1,0,0,0,0));   // rise alone does nothing
    add(0,1,0,0,0, ev(2,0,0,0,0));   // -> PAUSE
    add(1,0,0,0,0, ev(2,0,0,0,0));
    add(0,1,1,0,0, ev(1,0,0,0,0));   // fall + bt2 in PAUSE: RUN, no cnt_reset
    add(1,0,0,0,0, ev(1,0,0,0,0));
    add(0,1,0,0,0, ev(2,0,0,0,0));
    add(0,0,1,0,0, ev(0,0,1,0,0));   // bt2 in PAUSE -> IDLE with cnt_reset
    add(1,0,0,0,0, ev(0,0,0,0,0));   // long press
    for (int i = 0; i < LP - 1; i++) add(0,0,0,1,0, ev(0,0,0,0,0));
    add(0,0,0,1,0, ev(3,0,0,0,0));
    add(0,1,0,0,0, ev(3,0,0,0,0));   // fall of long press ignored
    add(0,0,1,0,0, ev(3,0,0,1,0));
    add(0,0,0,0,0, ev(3,0,0,0,0));
    add(0,0,1,0,0, ev(3,0,0,1,0));
    add(0,0,1,0,0, ev(3,0,0,1,0));
    for (int d = 0; d < 3; d++) begin
      add(1,0,0,0,0, ev(3,0,0,0,d));
      add(0,1,0,0,0, ev(3,0,0,0,d + 1));
    end
    add(1,0,0,0,0, ev(3,0,0,0,3));
    add(0,1,0,0,0, ev(0,1,0,0,0));   // 4th short press -> load, IDLE
    add(0,0,0,0,0, ev(0,0,0,0,0));
    add(1,0,0,0,1, ev(0,0,0,0,0));   // short press with count_zero: stay IDLE
    add(0,1,0,0,1, ev(0,0,0,0,0));
    add(1,0,0,0,0, ev(0,0,0,0,0));
    add(0,1,0,0,0, ev(1,0,0,0,0));
    add(0,0,0,0,1, ev(4,0,0,0,0));   // zero in RUN -> ALARM
    for (int i = 0; i < AL - 1; i++) begin
      add(0,0,0,1,0, ev(4,0,0,0,0));
      add(0,0,0,0,0, ev(4,0,0,0,0));
    end
    add(0,0,0,1,0, ev(0,0,0,0,0));   // ALARM_LEN-th tick -> IDLE

    // reset state
    model_reset();
    #1 reset = 1'b1;
    #1 check("reset_state", dut_vec(), 11'd0);
    @(posedge clk); #1;
    check("reset_state_clk", dut_vec(), 11'd0);
    @(negedge clk) reset = 1'b0;

    foreach (vecs[i])
      stepx(vecs[i].r, vecs[i].f, vecs[i].b2, vecs[i].t, vecs[i].cz,
            $sformatf("vec%0d", i), vecs[i].exp);

    // tick coinciding with the rise is not counted
    stepx(1,0,0,1,0, "rise_tick", ev(0,0,0,0,0));
    for (int i = 0; i < LP - 1; i++) stepx(0,0,0,1,0, "rise_tick_hold", ev(0,0,0,0,0));
    stepx(0,0,0,1,0, "rise_tick_long", ev(3,0,0,0,0));
    stepx(0,1,0,0,0, "long_fall_ign", ev(3,0,0,0,0));
    // long press in PROG aborts without load
    stepx(1,0,0,0,0, "abort_rise", ev(3,0,0,0,0));
    for (int i = 0; i < LP - 1; i++) stepx(0,0,0,1,0, "abort_hold", ev(3,0,0,0,0));
    stepx(0,0,0,1,0, "abort_long", ev(0,0,0,0,0));
    stepx(0,1,0,0,0, "abort_fall_ign", ev(0,0,0,0,0));

    // alarm acknowledged by bt1: neither the hold nor the release acts later
    stepx(1,0,0,0,0, "ack_r", ev(0,0,0,0,0));
    stepx(0,1,0,0,0, "ack_run", ev(1,0,0,0,0));
    stepx(0,0,0,0,1, "ack_alarm", ev(4,0,0,0,0));
    stepx(1,0,0,0,0, "ack_bt1", ev(0,0,0,0,0));
    for (int i = 0; i < LP; i++) stepx(0,0,0,1,0, "ack_hold", ev(0,0,0,0,0));
    stepx(0,1,0,0,0, "ack_fall", ev(0,0,0,0,0));
    // alarm acknowledged by bt2
    stepx(1,0,0,0,0, "ack2_r", ev(0,0,0,0,0));
    stepx(0,1,0,0,0, "ack2_run", ev(1,0,0,0,0));
    stepx(0,0,0,0,1, "ack2_alarm", ev(4,0,0,0,0));
    for (int i = 0; i < 3; i++) stepx(0,0,0,1,0, "ack2_tick", ev(4,0,0,0,0));
    stepx(0,0,1,0,0, "ack_bt2", ev(0,0,0,0,0));

    // reset mid-PROG with a press pending
    stepx(1,0,0,0,0, "rp_r", ev(0,0,0,0,0));
    for (int i = 0; i < LP; i++) step(0,0,0,1,0, "rp_hold");
    stepx(0,1,0,0,0, "rp_prog", ev(3,0,0,0,0));
    for (int d = 1; d <= 2; d++) begin
      step(1,0,0,0,0, "rp_sr");
      stepx(0,1,0,0,0, "rp_sel", ev(3,0,0,0,d));
    end
    stepx(1,0,0,0,0, "rp_pending", ev(3,0,0,0,2));
    pulse_reset("rp_reset");
    stepx(0,1,0,0,0, "stray_fall", ev(0,0,0,0,0));

    // random traffic against the model
    begin
      bit btn, r, f, b2, t, cz;
      btn = 0; cz = 0;
      for (int i = 0; i < 4000; i++) begin
        r = 0; f = 0;
        if ($urandom_range(0, 19) == 0) begin
          if (btn) f = 1; else r = 1;
          btn = !btn;
        end else if (!btn && $urandom_range(0, 99) == 0) begin
          f = 1;
        end
        t  = ($urandom_range(0, 2) == 0);
        b2 = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 24) == 0) cz = !cz;
        if ($urandom_range(0, 599) == 0) pulse_reset("rand_reset");
        step(r, f, b2, t, cz, "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
